// File: rtl/xalu_muldiv_if.sv
// Mul/div unit bus: E-stage request, busy flag, HI/LO and read data.
// master drives start/flush/op/A/B; slave returns busy/HI/LO/XALUOut.
interface xalu_muldiv_if;
    logic        start;
    logic        flush;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] XALUOut;

    modport master (
        output start, flush, op, A, B,
        input  busy, HI, LO, XALUOut
    );

    modport slave (
        input  start, flush, op, A, B,
        output busy, HI, LO, XALUOut
    );
endinterface

// File: rtl/xalu_muldiv.sv
// E-stage multiply/divide unit owning HI/LO; results commit after a busy count.
// Ports: clk, reset_n (sync, active-low), bus (xalu_muldiv_if.slave). Macro XALU_MADD_EN enables ops 8-11.
module xalu_muldiv #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    xalu_muldiv_if.slave  bus
);
    localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MFHI  = 4'd6;
    localparam logic [3:0] OP_MFLO  = 4'd7;
`ifdef XALU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd8;
    localparam logic [3:0] OP_MADDU = 4'd9;
    localparam logic [3:0] OP_MSUB  = 4'd10;
    localparam logic [3:0] OP_MSUBU = 4'd11;
`endif

    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic [31:0]   r_phi;
    logic [31:0]   r_plo;
    logic [CW-1:0] r_cnt;
    logic          r_sup;

    logic          w_busy;
    logic          w_acc;
    logic [63:0]   w_sprod;
    logic [63:0]   w_uprod;
    logic [31:0]   w_bsafe;
    logic [31:0]   w_uquo;
    logic [31:0]   w_urem;
    logic [31:0]   w_ma;
    logic [31:0]   w_mb;
    logic [31:0]   w_qmag;
    logic [31:0]   w_rmag;
    logic [31:0]   w_squo;
    logic [31:0]   w_srem;
    logic          w_multi;
    logic          w_sup;
    logic [CW-1:0] w_lat;
    logic [63:0]   w_res;

    assign w_busy = (r_cnt != '0);
    assign w_acc  = bus.start && !bus.flush && !w_busy;

    // Low 64 bits of the sign-extended product equal the signed product.
    assign w_sprod = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    assign w_uprod = {32'd0, bus.A} * {32'd0, bus.B};

    // Divisor forced to 1 on zero: the result is discarded anyway.
    assign w_bsafe = (bus.B == 32'd0) ? 32'd1 : bus.B;
    assign w_uquo  = bus.A / w_bsafe;
    assign w_urem  = bus.A % w_bsafe;

    // Signed divide on magnitudes; 0x80000000/-1 falls out as 0x80000000 rem 0.
    assign w_ma   = bus.A[31] ? (32'd0 - bus.A) : bus.A;
    assign w_mb   = bus.B[31] ? (32'd0 - bus.B) : w_bsafe;
    assign w_qmag = w_ma / w_mb;
    assign w_rmag = w_ma % w_mb;
    assign w_squo = (bus.A[31] ^ bus.B[31]) ? (32'd0 - w_qmag) : w_qmag;
    assign w_srem = bus.A[31] ? (32'd0 - w_rmag) : w_rmag;

    always_comb begin
        w_multi = 1'b0;
        w_sup   = 1'b0;
        w_lat   = '0;
        w_res   = {r_hi, r_lo};
        case (bus.op)
            OP_MULT: begin
                w_multi = 1'b1;
                w_lat   = CW'(MULT_CYCLES);
                w_res   = w_sprod;
            end
            OP_MULTU: begin
                w_multi = 1'b1;
                w_lat   = CW'(MULT_CYCLES);
                w_res   = w_uprod;
            end
            OP_DIV: begin
                w_multi = 1'b1;
                w_lat   = CW'(DIV_CYCLES);
                w_sup   = (bus.B == 32'd0);
                w_res   = {w_srem, w_squo};
            end
            OP_DIVU: begin
                w_multi = 1'b1;
                w_lat   = CW'(DIV_CYCLES);
                w_sup   = (bus.B == 32'd0);
                w_res   = {w_urem, w_uquo};
            end
`ifdef XALU_MADD_EN
            OP_MADD: begin
                w_multi = 1'b1;
                w_lat   = CW'(MULT_CYCLES);
                w_res   = {r_hi, r_lo} + w_sprod;
            end
            OP_MADDU: begin
                w_multi = 1'b1;
                w_lat   = CW'(MULT_CYCLES);
                w_res   = {r_hi, r_lo} + w_uprod;
            end
            OP_MSUB: begin
                w_multi = 1'b1;
                w_lat   = CW'(MULT_CYCLES);
                w_res   = {r_hi, r_lo} - w_sprod;
            end
            OP_MSUBU: begin
                w_multi = 1'b1;
                w_lat   = CW'(MULT_CYCLES);
                w_res   = {r_hi, r_lo} - w_uprod;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_phi <= '0;
            r_plo <= '0;
            r_cnt <= '0;
            r_sup <= 1'b0;
        end else if (w_acc) begin
            if (bus.op == OP_MTHI) r_hi <= bus.A;
            if (bus.op == OP_MTLO) r_lo <= bus.A;
            if (w_multi) begin
                {r_phi, r_plo} <= w_res;
                r_cnt          <= w_lat;
                r_sup          <= w_sup;
            end
        end else if (w_busy) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CW'(1) && !r_sup) begin
                r_hi <= r_phi;
                r_lo <= r_plo;
            end
        end
    end

    assign bus.busy    = w_busy;
    assign bus.HI      = r_hi;
    assign bus.LO      = r_lo;
    assign bus.XALUOut = (bus.op == OP_MFHI) ? r_hi :
                         (bus.op == OP_MFLO) ? r_lo : 32'd0;
endmodule

// File: tb/tb_xalu_muldiv.sv
// Randomized self-checking bench for xalu_muldiv against an arithmetic HI/LO model.
// Honours XALU_MADD_EN the same way the design does.
module tb_xalu_muldiv;
    localparam int MC = 5;
    localparam int DC = 10;
`ifdef XALU_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    xalu_muldiv_if bus ();

    xalu_muldiv #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Architectural effect of an accepted op: latency, commit flag, new {HI,LO}.
    task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output bit cm, output logic [63:0] res);
        int sa, sb, q, r;
        logic [63:0] sp, up;
        sa = a;
        sb = b;
        sp = longint'(sa) * longint'(sb);
        up = {32'd0, a} * {32'd0, b};
        lat = 0;
        cm = 1'b0;
        res = {m_hi, m_lo};
        case (o)
            4'd0: begin lat = MC; cm = 1'b1; res = sp; end
            4'd1: begin lat = MC; cm = 1'b1; res = up; end
            4'd2: begin
                lat = DC;
                if (b != 0) begin
                    cm = 1'b1;
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        q = sa;
                        r = 0;
                    end else begin
                        q = sa / sb;
                        r = sa % sb;
                    end
                    res = {r, q};
                end
            end
            4'd3: begin
                lat = DC;
                if (b != 0) begin
                    cm = 1'b1;
                    res = {a % b, a / b};
                end
            end
            4'd4: begin cm = 1'b1; res = {a, m_lo}; end
            4'd5: begin cm = 1'b1; res = {m_hi, a}; end
            4'd8, 4'd9, 4'd10, 4'd11: begin
                if (MADD_EN) begin
                    lat = MC;
                    cm = 1'b1;
                    case (o)
                        4'd8:    res = {m_hi, m_lo} + sp;
                        4'd9:    res = {m_hi, m_lo} + up;
                        4'd10:   res = {m_hi, m_lo} - sp;
                        default: res = {m_hi, m_lo} - up;
                    endcase
                end
            end
            default: ;
        endcase
    endtask

    task automatic readback(input string tag);
        bus.op = 4'd6;
        #1 chk({tag, "_mfhi"}, bus.XALUOut, m_hi);
        bus.op = 4'd7;
        #1 chk({tag, "_mflo"}, bus.XALUOut, m_lo);
        bus.op = 4'd12;
        #1 chk({tag, "_xnop"}, bus.XALUOut, 32'd0);
        bus.op = 4'hF;
    endtask

    // Called at a negedge; returns at the negedge of the first idle cycle.
    task automatic run(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit fl, input string tag);
        int lat;
        bit cm;
        logic [63:0] res;
        model(o, a, b, lat, cm, res);
        if (fl) begin
            lat = 0;
            cm = 1'b0;
        end
        bus.start = 1'b1;
        bus.flush = fl;
        bus.op    = o;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 4'hF;
        for (int i = 0; i < lat; i++) begin
            chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
            chk({tag, "_hold"}, bus.LO, m_lo);
            @(negedge clk);
        end
        if (cm) {m_hi, m_lo} = res;
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
        chk({tag, "_hi"}, bus.HI, m_hi);
        chk({tag, "_lo"}, bus.LO, m_lo);
        readback(tag);
    endtask

    initial begin
        logic [31:0] sv [5];
        logic [31:0] a, b;
        logic [3:0]  o;
        int lat, n;
        bit cm;
        logic [63:0] res;

        sv[0] = 32'd0;
        sv[1] = 32'd1;
        sv[2] = 32'hFFFF_FFFF;
        sv[3] = 32'h8000_0000;
        sv[4] = 32'h7FFF_FFFF;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 4'hF;
        bus.A     = 32'd0;
        bus.B     = 32'd0;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_hi", bus.HI, 32'd0);
        chk("rst_lo", bus.LO, 32'd0);
        readback("rst");

        run(4'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, "mult");
        chk("mult_hi_k", bus.HI, 32'hFFFF_FFFF);
        chk("mult_lo_k", bus.LO, 32'hFFFF_FFFA);

        run(4'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div");
        chk("div_lo_k", bus.LO, 32'hFFFF_FFFD);
        chk("div_hi_k", bus.HI, 32'hFFFF_FFFF);

        run(4'd3, 32'd7, 32'd0, 1'b0, "divu0");
        chk("divu0_lo_k", bus.LO, 32'hFFFF_FFFD);

        run(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "divovf");
        chk("divovf_lo_k", bus.LO, 32'h8000_0000);
        chk("divovf_hi_k", bus.HI, 32'd0);

        run(4'd1, 32'd9, 32'd9, 1'b1, "flush");
        repeat (3) begin
            @(negedge clk);
            chk("flush_nobusy", 32'(bus.busy), 32'd0);
        end

        run(4'd4, 32'h1234, 32'd0, 1'b0, "mthi");
        chk("mthi_k", bus.HI, 32'h1234);

        // MTLO arriving in the 2nd busy cycle must be dropped.
        model(4'd0, 32'd11, 32'd13, lat, cm, res);
        bus.start = 1'b1;
        bus.op = 4'd0;
        bus.A = 32'd11;
        bus.B = 32'd13;
        @(negedge clk);
        bus.op = 4'hF;
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = 4'd5;
        bus.A = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op = 4'hF;
        n = 0;
        while (bus.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ign_tail", n, 32'd3);
        {m_hi, m_lo} = res;
        chk("ign_lo", bus.LO, 32'd143);
        chk("ign_hi", bus.HI, m_hi);

        // Reset in the 3rd busy cycle discards the multiply.
        bus.start = 1'b1;
        bus.op = 4'd1;
        bus.A = 32'hFFFF_FFFF;
        bus.B = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op = 4'hF;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_hi", bus.HI, 32'd0);
        chk("mrst_lo", bus.LO, 32'd0);
        repeat (6) begin
            @(negedge clk);
            chk("mrst_nocommit", bus.LO, 32'd0);
        end

        run(4'd4, 32'd0, 32'd0, 1'b0, "pre_hi");
        run(4'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, "pre_lo");
        run(4'd9, 32'd1, 32'd1, 1'b0, "maddu");
        chk("maddu_hi_k", bus.HI, MADD_EN ? 32'd1 : 32'd0);
        chk("maddu_lo_k", bus.LO, MADD_EN ? 32'd0 : 32'hFFFF_FFFF);

        for (int i = 0; i < 60; i++) begin
            o = 4'($urandom_range(0, 15));
            a = ($urandom_range(0, 3) == 0) ? sv[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? sv[$urandom_range(0, 4)] : $urandom;
            run(o, a, b, $urandom_range(0, 7) == 0, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule

// File: doc/xalu_muldiv.md
# xalu_muldiv

- Multiply/divide unit in the E stage, alongside the main ALU.
- Consumes the forwarded E-stage operands (MF_RSE → `A`, MF_RTE → `B`) and owns the HI/LO register pair.
- `XALUOut` is registered into the M pipeline register, where it becomes XALUOut_M, a forwarding source for the D- and E-stage operand muxes.
- Multi-cycle operations assert `busy`; the hazard unit uses `busy` to stall the D stage.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU (≥1).
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU (≥1).

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: reset is synchronous and active-low.
- `start` in 1: the E-stage instruction is a mul/div-class op this cycle.
- `flush` in 1: the E-stage instruction is being squashed; overrides `start`.
- `op` in 4: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO, 8 MADD, 9 MADDU, 10 MSUB, 11 MSUBU; all other codes are no-ops.
- `A` in 32: forwarded rs value.
- `B` in 32: forwarded rt value.
- `busy` out 1: a multi-cycle operation is in flight.
- `HI` out 32: architectural HI.
- `LO` out 32: architectural LO.
- `XALUOut` out 32: combinational. Equals `HI` when `op`=MFHI, `LO` when `op`=MFLO, else 0. Independent of `start` and `busy`.

## Operation
- **Reset** (`reset_n`=0 at an edge):
  - HI=0, LO=0, `busy`=0, counter=0, pending result cleared.
  - Any in-flight operation is discarded.
- **Accept**: an op is accepted when `start`=1, `flush`=0 and `busy`=0.
  - If `start`=1 while `busy`=1, the op is ignored: no state change, no operand latch. This is a protocol violation; the hazard unit prevents it.
- **MULT/MULTU**: 64-bit signed/unsigned product of `A`×`B`.
  - Captured at accept into shadow registers {pHI,pLO}.
  - Counter loaded with MULT_CYCLES.
- **DIV/DIVU**: signed/unsigned divide, computed at accept.
  - pLO = quotient, pHI = remainder.
  - Signed divide truncates toward zero; the remainder takes the dividend's sign.
  - Counter loaded with DIV_CYCLES.
  - Divide by zero: still busy for DIV_CYCLES, but the commit is suppressed and HI/LO keep their old values.
  - 0x80000000 / 0xFFFFFFFF (signed): pLO = 0x80000000, pHI = 0.
- **MADD-class ops**: see Configuration.
- **MTHI/MTLO**: at accept, HI (or LO) ← `A` on that same edge. No busy.
- **MFHI/MFLO**: read-only; no state change. `start` may be 1 or 0.
- **Counter**: decrements each cycle while nonzero; `busy` = (counter ≠ 0).
  - On the edge where the counter goes 1→0, HI/LO ← pHI/pLO, unless the commit was suppressed.
- **flush**:
  - Blocks acceptance in the cycle it is asserted.
  - Does not abort an already accepted operation.

## Timing
- Op accepted at the edge ending cycle T, with latency N (MULT_CYCLES or DIV_CYCLES):
  - `busy`=1 in cycles T+1 .. T+N.
  - HI/LO show the new values in cycle T+N+1, where `busy`=0.
- A new multi-cycle op may be accepted in cycle T+N+1: back-to-back with one idle-to-busy turnaround of zero cycles.
- MTHI/MTLO accepted at the end of T: visible on `HI`/`LO` in T+1.
- MFHI/MFLO in T+1 returns the new value.
- MFHI/MFLO during `busy`: `XALUOut` shows the pre-operation HI/LO. The hazard unit must stall the read until `busy`=0.
- `XALUOut` has zero latency: a combinational path from `op`, `HI`, `LO`.
- `reset_n`=0 in any cycle: all outputs are 0 in the next cycle, regardless of the counter.

## Configuration
- `XALU_MADD_EN` defined: ops 8–11 are implemented.
  - {HI,LO} ± signed or unsigned `A`×`B` (64-bit, wraps mod 2^64).
  - The accumulate base is the HI/LO value at accept time.
  - Latency is MULT_CYCLES.
- `XALU_MADD_EN` undefined: ops 8–11 behave as no-ops. No busy, no state change, `XALUOut`=0.

## Test plan
- **Signed multiply**: reset, then MULT with `A`=0xFFFFFFFE (−2), `B`=3.
  - `busy`=1 for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - MFHI then gives `XALUOut`=0xFFFFFFFF.
- **Divides**:
  - DIV `A`=−7, `B`=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU `A`=7, `B`=0 → busy for 10 cycles, HI/LO unchanged.
- **Ignored start / reset mid-operation**:
  - MULT accepted, then `start`=1 MTLO `A`=5 in the 2nd busy cycle → ignored, LO is the product after commit.
  - Separate run: `reset_n`=0 in the 3rd busy cycle → next cycle `busy`=0, HI=LO=0, and no commit follows.
- **Flush and move-to**:
  - `start`=1 MULTU with `flush`=1 → `busy` never rises, HI/LO unchanged.
  - MTHI `A`=0x1234 → HI=0x1234 the next cycle, and MFHI that cycle returns 0x1234.
- **MADD**, with `XALU_MADD_EN`:
  - Preload HI=0, LO=0xFFFFFFFF, then MADDU `A`=1, `B`=1 → HI=1, LO=0 after 5 cycles.
  - Without the macro, the same sequence leaves HI=0, LO=0xFFFFFFFF and `busy` stays 0.
